// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the pipeline front end.
// Holds the prefetch state encoding and the default word width / reset PC.
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = '0;

    // Prefetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding, queue full
        REQ  = 2'd1,  // live fetch outstanding, its data will be queued
        DROP = 2'd2   // stale fetch outstanding, its data will be thrown away
    } fq_state_t;

endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: small synchronous FIFO for fetched {inst, pc+1} entries.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
// clear empties the FIFO in one cycle and overrides push/pop.
module fq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 2 * WORD_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; clear wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents only matter while count covers them
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; validity is tracked by count alone.
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between imem and decode.
// Issues one word-addressed fetch at a time over req/ack, queues {inst, pc+1}
// and presents the head to decode over valid/ready. A redirect flushes the
// queue and turns any in-flight fetch into a discarded one.
// Optional build macro FETCH_QUEUE_BYPASS_EN: an ack arriving while the queue
// is empty is forwarded to decode combinationally in the same cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int             DEPTH    = 4,
    parameter int             W        = WORD_W,
    parameter logic [W-1:0]   RESET_PC = W'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  logic [W-1:0] redirect_pc,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_data,
    output logic         out_valid,
    output logic [W-1:0] out_inst,
    output logic [W-1:0] out_pc4,
    input  logic         out_ready
);

    localparam int             CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    fq_state_t      state;
    fq_state_t      state_next;
    logic [W-1:0]   fetch_pc;
    logic [W-1:0]   fetch_pc_next;
    logic [W-1:0]   addr_q;
    logic           req_q;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_after;
    logic [2*W-1:0] fifo_din;
    logic [2*W-1:0] fifo_dout;
    logic           fifo_empty;
    logic           accept;
    logic           byp_valid;
    logic           push;
    logic           pop;

    assign fifo_empty = (count == '0);

    // A returning word is kept only for a live fetch that is not being flushed
    assign accept = (state == REQ) && imem_ack && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_valid = accept && fifo_empty;
`else
    assign byp_valid = 1'b0;
`endif

    // A word consumed straight off the bypass path never enters the FIFO
    assign pop         = !fifo_empty && out_ready && !redirect;
    assign push        = accept && !(byp_valid && out_ready);
    assign fifo_din    = {imem_data, addr_q + W'(1)};
    assign count_after = count + CW'(push) - CW'(pop);

    fq_fifo #(
        .DEPTH (DEPTH),
        .DW    (2 * W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count)
    );

    // Present the FIFO head, or the returning word when bypassing an empty queue
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        out_valid = 1'b0;
        out_inst  = '0;
        out_pc4   = '0;
        if (!fifo_empty) begin
            out_valid = 1'b1;
            out_inst  = fifo_dout[2*W-1:W];
            out_pc4   = fifo_dout[W-1:0];
        end else if (byp_valid) begin
            out_valid = 1'b1;
            out_inst  = imem_data;
            out_pc4   = addr_q + W'(1);
        end
    end

    // Next fetch state and fetch PC; redirect overrides everything else
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        if (state == REQ && imem_ack) fetch_pc_next = fetch_pc + W'(1);
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            // An unfinished fetch must still be drained; otherwise restart at once
            if ((state == REQ || state == DROP) && !imem_ack) state_next = DROP;
            else                                               state_next = REQ;
        end else begin
            case (state)
                IDLE:    if (count_after < FULL_COUNT) state_next = REQ;
                REQ:     if (imem_ack) state_next = (count_after < FULL_COUNT) ? REQ : IDLE;
                DROP:    if (imem_ack) state_next = REQ;
                default: state_next = IDLE;
            endcase
        end
    end

    // Registered sequencer state and memory-side request; DROP holds the stale address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (state_next != DROP) addr_q <= fetch_pc_next;
            req_q    <= (state_next != IDLE);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

endmodule
